// File: rtl/calc_rr_sched.sv
// calc_rr_sched: schedules four requester ports onto the add/sub lane (1) and the
// shift lane (2). Define CALC_FIXED_PRIO_EN for legacy fixed-priority lane grant.
module calc_rr_sched #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 8
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic [3:0]  req_vld,
   input  logic [15:0] req_cmd,
   output logic [3:0]  req_ready,
   output logic        alu1_go,
   output logic [3:0]  alu1_cmd,
   output logic [1:0]  alu1_id,
   input  logic        alu1_done,
   input  logic        alu1_flag,
   output logic        alu2_go,
   output logic [3:0]  alu2_cmd,
   output logic [1:0]  alu2_id,
   input  logic        alu2_done,
   input  logic        alu2_flag,
   output logic [3:0]  resp_vld,
   output logic [7:0]  resp_code,
   output logic        sched_busy
);

   // state  | meaning
   // IDLE   | ready for a new command
   // PEND   | valid command held, waiting for a lane grant
   // ISSUED | dispatched, waiting for lane done or watchdog
   // RESP   | response code presented for one cycle
   typedef enum logic [1:0] {IDLE, PEND, ISSUED, RESP} port_state_t;

   port_state_t      state_q [4];
   port_state_t      state_d [4];
   logic [3:0]       cmd_q   [4];
   logic [1:0]       code_q  [4];
   logic [1:0]       code_d  [4];

   logic [1:0]       lane_busy;
   logic [3:0]       lane_cmd [2];
   logic [1:0]       lane_id  [2];
   logic [CNT_W-1:0] lane_cnt [2];
   logic [1:0]       grant_id [2];
   logic [3:0]       pend     [2];
   logic [1:0]       alu_done, alu_flag, fin, fire, grant_vld;
   logic             ln;

   assign alu_done = {alu2_done, alu1_done};
   assign alu_flag = {alu2_flag, alu1_flag};

   function automatic logic cmd_ok(input logic [3:0] c);
      return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
   endfunction

   // 0 = add/sub lane, 1 = shift lane
   function automatic logic cmd_lane(input logic [3:0] c);
      return (c == 4'd5) || (c == 4'd6);
   endfunction

   always_comb begin
      fin  = '0;
      fire = '0;
      for (int l = 0; l < 2; l++) begin
         pend[l] = '0;
         for (int p = 0; p < 4; p++)
            pend[l][p] = (state_q[p] == PEND) && (cmd_lane(cmd_q[p]) == l[0]);
         fin[l]  = lane_busy[l] & alu_done[l];
         fire[l] = lane_busy[l] & ~alu_done[l] & (lane_cnt[l] == CNT_W'(TIMEOUT - 1));
      end
   end

`ifdef CALC_FIXED_PRIO_EN
   always_comb begin
      grant_vld = '0;
      for (int l = 0; l < 2; l++) begin
         grant_id[l] = '0;
         for (int i = 3; i >= 0; i--) begin
            if (!lane_busy[l] && pend[l][i]) begin
               grant_vld[l] = 1'b1;
               grant_id[l]  = 2'(i);
            end
         end
      end
   end
`else
   logic [1:0] lane_ptr [2];
   logic [1:0] idx;

   // descending scan so the port nearest ptr+1 is the one left standing
   always_comb begin
      grant_vld = '0;
      idx       = '0;
      for (int l = 0; l < 2; l++) begin
         grant_id[l] = '0;
         for (int i = 4; i >= 1; i--) begin
            idx = lane_ptr[l] + 2'(i);
            if (!lane_busy[l] && pend[l][idx]) begin
               grant_vld[l] = 1'b1;
               grant_id[l]  = idx;
            end
         end
      end
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         for (int l = 0; l < 2; l++) lane_ptr[l] <= 2'd3;
      end else begin
         for (int l = 0; l < 2; l++)
            if (grant_vld[l]) lane_ptr[l] <= grant_id[l];
      end
   end
`endif

   always_comb begin
      ln = 1'b0;
      for (int p = 0; p < 4; p++) begin
         state_d[p] = state_q[p];
         code_d[p]  = code_q[p];
         ln         = cmd_lane(cmd_q[p]);
         case (state_q[p])
            IDLE: begin
               if (req_vld[p]) begin
                  if (cmd_ok(req_cmd[4*p +: 4])) begin
                     state_d[p] = PEND;
                  end else begin
                     state_d[p] = RESP;
                     code_d[p]  = 2'b10;
                  end
               end
            end
            PEND: begin
               if (grant_vld[ln] && grant_id[ln] == 2'(p)) state_d[p] = ISSUED;
            end
            ISSUED: begin
               if (lane_id[ln] == 2'(p)) begin
                  if (fin[ln]) begin
                     state_d[p] = RESP;
                     code_d[p]  = alu_flag[ln] ? 2'b10 : 2'b01;
                  end else if (fire[ln]) begin
                     state_d[p] = RESP;
                     code_d[p]  = 2'b11;
                  end
               end
            end
            default: state_d[p] = IDLE;
         endcase
      end
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < 4; p++) begin
            state_q[p] <= IDLE;
            cmd_q[p]   <= '0;
            code_q[p]  <= '0;
         end
      end else begin
         for (int p = 0; p < 4; p++) begin
            state_q[p] <= state_d[p];
            code_q[p]  <= code_d[p];
            if (state_q[p] == IDLE && req_vld[p]) cmd_q[p] <= req_cmd[4*p +: 4];
         end
      end
   end

   // done has priority over the watchdog: fire already excludes alu_done
   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         lane_busy <= '0;
         for (int l = 0; l < 2; l++) begin
            lane_cmd[l] <= '0;
            lane_id[l]  <= '0;
            lane_cnt[l] <= '0;
         end
      end else begin
         for (int l = 0; l < 2; l++) begin
            if (grant_vld[l]) begin
               lane_busy[l] <= 1'b1;
               lane_cmd[l]  <= cmd_q[grant_id[l]];
               lane_id[l]   <= grant_id[l];
               lane_cnt[l]  <= '0;
            end else if (fin[l] || fire[l]) begin
               lane_busy[l] <= 1'b0;
            end else if (lane_busy[l]) begin
               lane_cnt[l]  <= lane_cnt[l] + 1'b1;
            end
         end
      end
   end

   assign alu1_go    = grant_vld[0];
   assign alu1_cmd   = grant_vld[0] ? cmd_q[grant_id[0]] : lane_cmd[0];
   assign alu1_id    = grant_vld[0] ? grant_id[0] : lane_id[0];
   assign alu2_go    = grant_vld[1];
   assign alu2_cmd   = grant_vld[1] ? cmd_q[grant_id[1]] : lane_cmd[1];
   assign alu2_id    = grant_vld[1] ? grant_id[1] : lane_id[1];
   assign sched_busy = |lane_busy;

   always_comb begin
      req_ready = '0;
      resp_vld  = '0;
      resp_code = '0;
      for (int p = 0; p < 4; p++) begin
         req_ready[p] = (state_q[p] == IDLE);
         resp_vld[p]  = (state_q[p] == RESP);
         if (state_q[p] == RESP) resp_code[2*p +: 2] = code_q[p];
      end
   end

endmodule

// File: tb/tb_calc_rr_sched.sv
// Randomized bench for calc_rr_sched: a cycle-level transaction model predicts
// grants, responses and port readiness into queues; a monitor checks the DUT.
module tb_calc_rr_sched;
   localparam int TIMEOUT = 15;
   localparam int BIG     = 32'h3fff_ffff;

   logic        c_clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req_vld = '0;
   logic [15:0] req_cmd = '0;
   logic [3:0]  req_ready;
   logic        alu1_go, alu2_go;
   logic [3:0]  alu1_cmd, alu2_cmd;
   logic [1:0]  alu1_id, alu2_id;
   logic        alu1_done = 1'b0, alu1_flag = 1'b0;
   logic        alu2_done = 1'b0, alu2_flag = 1'b0;
   logic [3:0]  resp_vld;
   logic [7:0]  resp_code;
   logic        sched_busy;

   calc_rr_sched #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
      .c_clk(c_clk), .reset(reset),
      .req_vld(req_vld), .req_cmd(req_cmd), .req_ready(req_ready),
      .alu1_go(alu1_go), .alu1_cmd(alu1_cmd), .alu1_id(alu1_id),
      .alu1_done(alu1_done), .alu1_flag(alu1_flag),
      .alu2_go(alu2_go), .alu2_cmd(alu2_cmd), .alu2_id(alu2_id),
      .alu2_done(alu2_done), .alu2_flag(alu2_flag),
      .resp_vld(resp_vld), .resp_code(resp_code), .sched_busy(sched_busy)
   );

   always #5 c_clk = ~c_clk;

   int cyc = 0;
   always @(posedge c_clk) cyc <= cyc + 1;

   typedef struct {int cyc; int lane; logic [1:0] id; logic [3:0] cmd;} go_t;
   typedef struct {int cyc; int port; logic [1:0] code;} rsp_t;
   typedef struct {int cyc; logic [3:0] rdy; logic busy;} st_t;

   go_t  go_q[$];
   rsp_t rsp_q[$];
   st_t  st_q[$];

   int checks = 0;
   int errors = 0;
   bit run = 1'b0;

   // reference model state
   int         idle_from [4];
   bit         pend      [4];
   int         pend_from [4];
   logic [3:0] p_cmd     [4];
   int         l_go   [2];
   int         l_end  [2];
   int         l_d    [2];
   int         l_late [2];
   int         l_last [2];
   bit         l_flag [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [3:0] pick_cmd();
      case ($urandom % 10)
         0, 1:    return 4'd1;
         2:       return 4'd2;
         3, 4:    return 4'd5;
         5:       return 4'd6;
         6:       return 4'd0;
         7:       return 4'd7;
         8:       return 4'hf;
         default: return 4'd3;
      endcase
   endfunction

   function automatic int pick_delay();
      int r;
      r = $urandom % 12;
      if (r < 8)   return 1 + int'($urandom % 4);
      if (r == 8)  return TIMEOUT;
      if (r == 9)  return TIMEOUT + 1;
      return TIMEOUT + 6;
   endfunction

   function automatic int lane_of(input logic [3:0] c);
      return (c == 4'd5 || c == 4'd6) ? 1 : 0;
   endfunction

   function automatic bit cmd_ok(input logic [3:0] c);
      return c == 4'd1 || c == 4'd2 || c == 4'd5 || c == 4'd6;
   endfunction

   task automatic push_rsp(input int c, input int p, input logic [1:0] code);
      rsp_t r;
      int   i;
      r.cyc = c; r.port = p; r.code = code;
      i = rsp_q.size();
      while (i > 0 && rsp_q[i-1].cyc > c) i--;
      rsp_q.insert(i, r);
   endtask

   // one model cycle: inputs driven now are sampled at the coming rising edge
   task automatic step(input bit gen);
      int         c, sel, q;
      st_t        st;
      go_t        g;
      logic [3:0] vld, cm;
      logic [15:0] cmdv;
      logic [1:0] dn, fl;
      c = cyc;
      st.cyc = c; st.rdy = '0; st.busy = 1'b0;
      for (int p = 0; p < 4; p++) st.rdy[p] = (c >= idle_from[p]);
      for (int l = 0; l < 2; l++) if (l_go[l] < c && c <= l_end[l]) st.busy = 1'b1;
      st_q.push_back(st);

      for (int l = 0; l < 2; l++) begin
         if (c > l_end[l]) begin
            sel = -1;
`ifdef CALC_FIXED_PRIO_EN
            for (int k = 3; k >= 0; k--)
               if (pend[k] && pend_from[k] <= c && lane_of(p_cmd[k]) == l) sel = k;
`else
            for (int k = 1; k <= 4; k++) begin
               q = (l_last[l] + k) % 4;
               if (sel < 0 && pend[q] && pend_from[q] <= c && lane_of(p_cmd[q]) == l) sel = q;
            end
`endif
            if (sel >= 0) begin
               l_last[l] = sel;
               pend[sel] = 1'b0;
               l_go[l]   = c;
               l_d[l]    = pick_delay();
               l_flag[l] = 1'($urandom % 2);
               g.cyc = c; g.lane = l; g.id = 2'(sel); g.cmd = p_cmd[sel];
               go_q.push_back(g);
               if (l_d[l] <= TIMEOUT) begin
                  l_end[l] = c + l_d[l];
                  push_rsp(l_end[l] + 1, sel, l_flag[l] ? 2'b10 : 2'b01);
               end else begin
                  l_end[l] = c + TIMEOUT;
                  push_rsp(l_end[l] + 1, sel, 2'b11);
                  if (l_d[l] == TIMEOUT + 1) l_late[l] = c + TIMEOUT + 1;
               end
               idle_from[sel] = l_end[l] + 2;
            end
         end
      end

      // emulated ALU lanes: real completions plus late and stray dones while idle
      dn = '0; fl = '0;
      for (int l = 0; l < 2; l++) begin
         if (l_d[l] <= TIMEOUT && c == l_go[l] + l_d[l]) begin
            dn[l] = 1'b1; fl[l] = l_flag[l];
         end else if (!(l_go[l] < c && c <= l_end[l])) begin
            if (c == l_late[l] || ($urandom % 7) == 0) begin
               dn[l] = 1'b1; fl[l] = 1'($urandom % 2);
            end
         end
      end

      vld = '0; cmdv = '0;
      for (int p = 0; p < 4; p++) begin
         cm = pick_cmd();
         cmdv[4*p +: 4] = cm;
         vld[p] = gen && (($urandom % 10) < 6);
         if (vld[p] && c >= idle_from[p]) begin
            if (cmd_ok(cm)) begin
               pend[p] = 1'b1; pend_from[p] = c + 1; p_cmd[p] = cm;
               idle_from[p] = BIG;
            end else begin
               push_rsp(c + 1, p, 2'b10);
               idle_from[p] = c + 2;
            end
         end
      end
      req_vld = vld; req_cmd = cmdv;
      alu1_done = dn[0]; alu1_flag = fl[0];
      alu2_done = dn[1]; alu2_flag = fl[1];
   endtask

   // monitor
   int         m_cur;
   st_t        m_st;
   go_t        m_g;
   rsp_t       m_r;
   logic [1:0] m_go;
   logic [1:0] m_id [2];
   logic [3:0] m_cmd [2];
   logic [3:0] m_rv;
   logic [7:0] m_rc, m_mask;

   always @(negedge c_clk) begin
      #1;
      if (run) begin
         m_cur = cyc;
         if (st_q.size() > 0) begin
            m_st = st_q.pop_front();
            chk("status_cycle", m_st.cyc, m_cur);
            chk("req_ready", req_ready, m_st.rdy);
            chk("sched_busy", sched_busy, m_st.busy);
         end
         m_go = '0;
         for (int l = 0; l < 2; l++) begin m_id[l] = '0; m_cmd[l] = '0; end
         while (go_q.size() > 0 && go_q[0].cyc <= m_cur) begin
            m_g = go_q.pop_front();
            m_go[m_g.lane]  = 1'b1;
            m_id[m_g.lane]  = m_g.id;
            m_cmd[m_g.lane] = m_g.cmd;
         end
         chk("alu_go", {alu2_go, alu1_go}, m_go);
         if (m_go[0] && alu1_go) begin
            chk("alu1_id", alu1_id, m_id[0]);
            chk("alu1_cmd", alu1_cmd, m_cmd[0]);
         end
         if (m_go[1] && alu2_go) begin
            chk("alu2_id", alu2_id, m_id[1]);
            chk("alu2_cmd", alu2_cmd, m_cmd[1]);
         end
         m_rv = '0; m_rc = '0; m_mask = '0;
         while (rsp_q.size() > 0 && rsp_q[0].cyc <= m_cur) begin
            m_r = rsp_q.pop_front();
            m_rv[m_r.port] = 1'b1;
            m_rc[2*m_r.port +: 2] = m_r.code;
            m_mask[2*m_r.port +: 2] = 2'b11;
         end
         chk("resp_vld", resp_vld, m_rv);
         if (m_rv != 4'b0) chk("resp_code", resp_code & m_mask, m_rc);
      end
   end

   initial begin
      for (int p = 0; p < 4; p++) begin
         idle_from[p] = 0; pend[p] = 1'b0; pend_from[p] = 0; p_cmd[p] = '0;
      end
      for (int l = 0; l < 2; l++) begin
         l_go[l] = -100; l_end[l] = -1; l_d[l] = 1; l_late[l] = -1;
         l_last[l] = 3; l_flag[l] = 1'b0;
      end

      reset = 1'b0;
      req_vld = 4'b1111;
      req_cmd = 16'h1651;
      repeat (4) begin
         @(negedge c_clk);
         #1;
         chk("rst_req_ready", req_ready, 4'b1111);
         chk("rst_go", {alu2_go, alu1_go}, 2'b00);
         chk("rst_resp_vld", resp_vld, 4'b0000);
         chk("rst_resp_code", resp_code, 8'h00);
         chk("rst_alu_cmd_id", {alu1_cmd, alu1_id, alu2_cmd, alu2_id}, 12'h000);
         chk("rst_busy", sched_busy, 1'b0);
      end

      @(negedge c_clk);
      reset = 1'b1;
      run   = 1'b1;
      step(1'b1);
      repeat (3000) begin
         @(negedge c_clk);
         step(1'b1);
      end
      repeat (150) begin
         @(negedge c_clk);
         step(1'b0);
      end
      #2;
      run = 1'b0;
      chk("go_queue_drained", go_q.size(), 0);
      chk("rsp_queue_drained", rsp_q.size(), 0);
      chk("final_ready", req_ready, 4'b1111);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
